// File: rtl/mips_bus_arbiter.sv
// Avalon-MM master sequencer shared by instruction fetch and data load/store.
// Round-robin grant, waitrequest hold, store lane steering, load extraction.
module mips_bus_arbiter #(
   parameter int unsigned WAIT_LIMIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic [31:0] f_rdata,
   output logic        f_done,
   output logic        f_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_signed,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

   state_t      state;
   grant_t      last_grant;
   grant_t      cur_grant;
   logic [1:0]  r_lane;
   logic [1:0]  r_size;
   logic        r_signed;
   logic        r_we;
   logic [31:0] stall_cnt;

   logic        grant_data;
   logic [31:0] sel_addr;
   logic [1:0]  sel_size;
   logic        sel_we;
   logic        sel_signed;
   logic [31:0] sel_wdata;
   logic        misaligned;
   logic [3:0]  sel_be;
   logic [31:0] sel_wd;
   logic [31:0] rd_shift;
   logic [31:0] load_ext;

   // Request selection and lane steering for the port that would win this cycle.
   always_comb begin
      grant_data = d_req && (!f_req || last_grant == GRANT_FETCH);
      if (grant_data) begin
         sel_addr   = d_addr;
         sel_size   = d_size;
         sel_we     = d_we;
         sel_signed = d_signed;
         sel_wdata  = d_wdata;
      end else begin
         sel_addr   = f_addr;
         sel_size   = 2'b10;
         sel_we     = 1'b0;
         sel_signed = 1'b0;
         sel_wdata  = '0;
      end

      case (sel_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = sel_addr[0];
         2'b10:   misaligned = (sel_addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase

      sel_be = 4'b1111;
      sel_wd = sel_wdata;
      case (sel_size)
         2'b00: begin
            sel_be = 4'b0001 << sel_addr[1:0];
            sel_wd = {24'b0, sel_wdata[7:0]} << {sel_addr[1:0], 3'b000};
         end
         2'b01: begin
            sel_be = sel_addr[1] ? 4'b1100 : 4'b0011;
            sel_wd = sel_addr[1] ? {sel_wdata[15:0], 16'b0} : {16'b0, sel_wdata[15:0]};
         end
         default: ;
      endcase
      if (!sel_we)
         sel_wd = '0;
   end

   always_comb begin
      rd_shift = readdata >> {r_lane, 3'b000};
      case (r_size)
         2'b00:   load_ext = {{24{r_signed & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   load_ext = {{16{r_signed & rd_shift[15]}}, rd_shift[15:0]};
         default: load_ext = readdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= GRANT_DATA;
         cur_grant  <= GRANT_FETCH;
         r_lane     <= '0;
         r_size     <= '0;
         r_signed   <= 1'b0;
         r_we       <= 1'b0;
         stall_cnt  <= '0;
         f_rdata    <= '0;
         f_done     <= 1'b0;
         f_err      <= 1'b0;
         d_rdata    <= '0;
         d_done     <= 1'b0;
         d_err      <= 1'b0;
         address    <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         writedata  <= '0;
         byteenable <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (f_req || d_req) begin
                  cur_grant  <= grant_data ? GRANT_DATA : GRANT_FETCH;
                  last_grant <= grant_data ? GRANT_DATA : GRANT_FETCH;
                  r_lane     <= sel_addr[1:0];
                  r_size     <= sel_size;
                  r_signed   <= sel_signed;
                  r_we       <= sel_we;
                  stall_cnt  <= '0;
                  busy       <= 1'b1;
                  if (misaligned) begin
                     state <= DONE;
                     if (grant_data) begin
                        d_done <= 1'b1;
                        d_err  <= 1'b1;
                     end else begin
                        f_done <= 1'b1;
                        f_err  <= 1'b1;
                     end
                  end else begin
                     state      <= ACCESS;
                     address    <= {sel_addr[31:2], 2'b00};
                     read       <= !sel_we;
                     write      <= sel_we;
                     byteenable <= sel_be;
                     writedata  <= sel_wd;
                  end
               end
            end
            ACCESS: begin
               if (!waitrequest) begin
                  state <= DONE;
                  read  <= 1'b0;
                  write <= 1'b0;
                  if (cur_grant == GRANT_DATA) begin
                     d_done <= 1'b1;
                     if (!r_we)
                        d_rdata <= load_ext;
                  end else begin
                     f_done  <= 1'b1;
                     f_rdata <= readdata;
                  end
               end else begin
                  stall_cnt <= stall_cnt + 32'd1;
                  // Count already holds the stalls before this one, so limit-1 means this is the last allowed.
                  if (WAIT_LIMIT != 0 && stall_cnt == WAIT_LIMIT - 1) begin
                     state <= DONE;
                     read  <= 1'b0;
                     write <= 1'b0;
                     if (cur_grant == GRANT_DATA) begin
                        d_done <= 1'b1;
                        d_err  <= 1'b1;
                     end else begin
                        f_done <= 1'b1;
                        f_err  <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy   <= 1'b0;
               f_done <= 1'b0;
               f_err  <= 1'b0;
               d_done <= 1'b0;
               d_err  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: one unlimited instance carries all traffic,
// a WAIT_LIMIT=4 twin on the same inputs covers the stall timeout.
module tb_mips_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        f_req = 1'b0;
   logic [31:0] f_addr = '0;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [1:0]  d_size = 2'b10;
   logic        d_signed = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = '0;

   logic [31:0] f_rdata, d_rdata, address, writedata;
   logic        f_done, f_err, d_done, d_err, read, write, busy;
   logic [3:0]  byteenable;

   logic [31:0] l_f_rdata, l_d_rdata, l_address, l_writedata;
   logic        l_f_done, l_f_err, l_d_done, l_d_err, l_read, l_write, l_busy;
   logic [3:0]  l_byteenable;

   int n_vec = 0;
   int n_miss = 0;
   logic [31:0] exp_f_rdata = '0;
   logic [31:0] exp_d_rdata = '0;

   always #5 clk = ~clk;

   mips_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done), .f_err(f_err),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
      .address(address), .read(read), .write(write), .waitrequest(waitrequest),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata), .busy(busy)
   );

   mips_bus_arbiter #(.WAIT_LIMIT(4)) dut_lim (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_rdata(l_f_rdata), .f_done(l_f_done), .f_err(l_f_err),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(l_d_rdata), .d_done(l_d_done), .d_err(l_d_err),
      .address(l_address), .read(l_read), .write(l_write), .waitrequest(waitrequest),
      .writedata(l_writedata), .byteenable(l_byteenable), .readdata(readdata), .busy(l_busy)
   );

   always @(negedge clk) begin
      if (!reset) begin
         n_vec++;
         if (read && write) begin
            $display("FAIL strobe_exclusive: read=%b write=%b, required not both high", read, write);
            n_miss++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_f_rdata = '0;
      exp_d_rdata = '0;
   endtask

   task automatic test_reset;
      pulse_reset();
      n_vec++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_miss++; end
      n_vec++; if (read !== 1'b0 || write !== 1'b0) begin $display("FAIL reset_strobes: got %b%b want 00", read, write); n_miss++; end
      n_vec++; if (address !== 32'h0) begin $display("FAIL reset_address: got %h want 0", address); n_miss++; end
      n_vec++; if (byteenable !== 4'h0 || writedata !== 32'h0) begin $display("FAIL reset_lanes: got be=%b wd=%h want 0", byteenable, writedata); n_miss++; end
      n_vec++; if ({f_done, f_err, d_done, d_err} !== 4'b0) begin $display("FAIL reset_done: got %b want 0000", {f_done, f_err, d_done, d_err}); n_miss++; end
      n_vec++; if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h/%h want 0/0", f_rdata, d_rdata); n_miss++; end
   endtask

   task automatic test_fetch;
      f_addr = 32'hBFC0_0000;
      readdata = 32'h2402_0005;
      waitrequest = 1'b0;
      f_req = 1'b1;
      tick();
      n_vec++; if (read !== 1'b1 || write !== 1'b0) begin $display("FAIL fetch_strobe: got r=%b w=%b want r=1 w=0", read, write); n_miss++; end
      n_vec++; if (address !== 32'hBFC0_0000) begin $display("FAIL fetch_addr: got %h want bfc00000", address); n_miss++; end
      n_vec++; if (byteenable !== 4'b1111) begin $display("FAIL fetch_be: got %b want 1111", byteenable); n_miss++; end
      n_vec++; if (busy !== 1'b1) begin $display("FAIL fetch_busy: got %b want 1", busy); n_miss++; end
      tick();
      exp_f_rdata = 32'h2402_0005;
      n_vec++; if (f_done !== 1'b1 || f_err !== 1'b0 || d_done !== 1'b0) begin $display("FAIL fetch_done: got f_done=%b f_err=%b d_done=%b want 1 0 0", f_done, f_err, d_done); n_miss++; end
      n_vec++; if (f_rdata !== exp_f_rdata) begin $display("FAIL fetch_rdata: got %h want %h", f_rdata, exp_f_rdata); n_miss++; end
      n_vec++; if (read !== 1'b0) begin $display("FAIL fetch_read_drop: got %b want 0", read); n_miss++; end
      f_req = 1'b0;
      tick();
      n_vec++; if (f_done !== 1'b0 || busy !== 1'b0) begin $display("FAIL fetch_idle: got f_done=%b busy=%b want 0 0", f_done, busy); n_miss++; end
      n_vec++; if (f_rdata !== exp_f_rdata) begin $display("FAIL fetch_rdata_hold: got %h want %h", f_rdata, exp_f_rdata); n_miss++; end
   endtask

   task automatic test_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                             input int unsigned nwait, input logic [3:0] exp_be, input logic [31:0] exp_wd);
      d_addr = addr;
      d_size = size;
      d_we = 1'b1;
      d_wdata = wdata;
      waitrequest = (nwait != 0);
      d_req = 1'b1;
      tick();
      for (int unsigned i = 0; i <= nwait; i++) begin
         if (i == nwait) waitrequest = 1'b0;
         n_vec++; if (write !== 1'b1 || read !== 1'b0) begin $display("FAIL store_strobe[%0d] @%h: got w=%b r=%b want w=1 r=0", i, addr, write, read); n_miss++; end
         n_vec++; if (address !== {addr[31:2], 2'b00}) begin $display("FAIL store_addr @%h: got %h want %h", addr, address, {addr[31:2], 2'b00}); n_miss++; end
         n_vec++; if (byteenable !== exp_be) begin $display("FAIL store_be @%h: got %b want %b", addr, byteenable, exp_be); n_miss++; end
         n_vec++; if (writedata !== exp_wd) begin $display("FAIL store_wdata @%h: got %h want %h", addr, writedata, exp_wd); n_miss++; end
         n_vec++; if (d_done !== 1'b0) begin $display("FAIL store_early_done @%h: got %b want 0", addr, d_done); n_miss++; end
         tick();
      end
      n_vec++; if (d_done !== 1'b1 || d_err !== 1'b0 || write !== 1'b0) begin $display("FAIL store_done @%h: got done=%b err=%b w=%b want 1 0 0", addr, d_done, d_err, write); n_miss++; end
      n_vec++; if (d_rdata !== exp_d_rdata) begin $display("FAIL store_rdata_hold @%h: got %h want %h", addr, d_rdata, exp_d_rdata); n_miss++; end
      d_req = 1'b0;
      tick();
      n_vec++; if (d_done !== 1'b0 || busy !== 1'b0) begin $display("FAIL store_idle @%h: got done=%b busy=%b want 0 0", addr, d_done, busy); n_miss++; end
   endtask

   task automatic test_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                            input logic [31:0] rd, input logic [3:0] exp_be, input logic [31:0] exp_val);
      d_addr = addr;
      d_size = size;
      d_we = 1'b0;
      d_signed = sgn;
      readdata = rd;
      waitrequest = 1'b0;
      d_req = 1'b1;
      tick();
      n_vec++; if (read !== 1'b1 || write !== 1'b0) begin $display("FAIL load_strobe @%h: got r=%b w=%b want r=1 w=0", addr, read, write); n_miss++; end
      n_vec++; if (address !== {addr[31:2], 2'b00}) begin $display("FAIL load_addr @%h: got %h want %h", addr, address, {addr[31:2], 2'b00}); n_miss++; end
      n_vec++; if (byteenable !== exp_be) begin $display("FAIL load_be @%h: got %b want %b", addr, byteenable, exp_be); n_miss++; end
      tick();
      exp_d_rdata = exp_val;
      n_vec++; if (d_done !== 1'b1 || d_err !== 1'b0) begin $display("FAIL load_done @%h: got done=%b err=%b want 1 0", addr, d_done, d_err); n_miss++; end
      n_vec++; if (d_rdata !== exp_val) begin $display("FAIL load_rdata @%h s=%b: got %h want %h", addr, sgn, d_rdata, exp_val); n_miss++; end
      d_req = 1'b0;
      tick();
   endtask

   task automatic test_misaligned(input logic is_fetch, input logic [31:0] addr, input logic [1:0] size);
      if (is_fetch) begin
         f_addr = addr;
         f_req = 1'b1;
      end else begin
         d_addr = addr;
         d_size = size;
         d_we = 1'b0;
         d_req = 1'b1;
      end
      waitrequest = 1'b0;
      tick();
      n_vec++; if (read !== 1'b0 || write !== 1'b0) begin $display("FAIL misalign_strobe @%h: got r=%b w=%b want 0 0", addr, read, write); n_miss++; end
      n_vec++; if (busy !== 1'b1) begin $display("FAIL misalign_busy @%h: got %b want 1", addr, busy); n_miss++; end
      if (is_fetch) begin
         n_vec++; if (f_done !== 1'b1 || f_err !== 1'b1 || d_done !== 1'b0) begin $display("FAIL misalign_fdone @%h: got done=%b err=%b d_done=%b want 1 1 0", addr, f_done, f_err, d_done); n_miss++; end
         n_vec++; if (f_rdata !== exp_f_rdata) begin $display("FAIL misalign_frdata @%h: got %h want %h", addr, f_rdata, exp_f_rdata); n_miss++; end
      end else begin
         n_vec++; if (d_done !== 1'b1 || d_err !== 1'b1 || f_done !== 1'b0) begin $display("FAIL misalign_ddone @%h: got done=%b err=%b f_done=%b want 1 1 0", addr, d_done, d_err, f_done); n_miss++; end
         n_vec++; if (d_rdata !== exp_d_rdata) begin $display("FAIL misalign_drdata @%h: got %h want %h", addr, d_rdata, exp_d_rdata); n_miss++; end
      end
      f_req = 1'b0;
      d_req = 1'b0;
      tick();
      n_vec++; if ({f_done, f_err, d_done, d_err, busy, read} !== 6'b0) begin $display("FAIL misalign_idle @%h: got %b want 000000", addr, {f_done, f_err, d_done, d_err, busy, read}); n_miss++; end
   endtask

   task automatic test_contention;
      logic is_d;
      logic [31:0] rd;
      pulse_reset();
      f_addr = 32'h0000_0100;
      d_addr = 32'h0000_0200;
      d_size = 2'b10;
      d_we = 1'b0;
      d_signed = 1'b0;
      waitrequest = 1'b0;
      f_req = 1'b1;
      d_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         is_d = (i % 2) == 1;
         rd = is_d ? 32'hD000_0000 + i : 32'hF000_0000 + i;
         readdata = rd;
         tick();
         n_vec++; if (address !== (is_d ? 32'h200 : 32'h100)) begin $display("FAIL contend_grant[%0d]: got addr %h want %h", i, address, is_d ? 32'h200 : 32'h100); n_miss++; end
         tick();
         n_vec++; if (d_done !== is_d || f_done !== !is_d) begin $display("FAIL contend_done[%0d]: got f=%b d=%b want f=%b d=%b", i, f_done, d_done, !is_d, is_d); n_miss++; end
         if (is_d) begin
            exp_d_rdata = rd;
            n_vec++; if (d_rdata !== rd) begin $display("FAIL contend_drdata[%0d]: got %h want %h", i, d_rdata, rd); n_miss++; end
            d_req = 1'b0;
         end else begin
            exp_f_rdata = rd;
            n_vec++; if (f_rdata !== rd) begin $display("FAIL contend_frdata[%0d]: got %h want %h", i, f_rdata, rd); n_miss++; end
            f_req = 1'b0;
         end
         tick();
         f_req = 1'b1;
         d_req = 1'b1;
      end
      f_req = 1'b0;
      d_req = 1'b0;
      tick();
   endtask

   task automatic test_timeout;
      d_addr = 32'h0000_0040;
      d_size = 2'b10;
      d_we = 1'b0;
      readdata = 32'h1357_9BDF;
      waitrequest = 1'b1;
      d_req = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (l_read !== 1'b1 || l_d_done !== 1'b0) begin $display("FAIL timeout_stall[%0d]: got r=%b done=%b want 1 0", i, l_read, l_d_done); n_miss++; end
         tick();
      end
      n_vec++; if (l_read !== 1'b0 || l_d_done !== 1'b1 || l_d_err !== 1'b1) begin $display("FAIL timeout_err: got r=%b done=%b err=%b want 0 1 1", l_read, l_d_done, l_d_err); n_miss++; end
      n_vec++; if (l_d_rdata !== exp_d_rdata) begin $display("FAIL timeout_rdata_hold: got %h want %h", l_d_rdata, exp_d_rdata); n_miss++; end
      for (int i = 0; i < 2; i++) begin
         n_vec++; if (read !== 1'b1 || d_done !== 1'b0 || address !== 32'h40) begin $display("FAIL nolimit_stall[%0d]: got r=%b done=%b addr=%h want 1 0 00000040", i, read, d_done, address); n_miss++; end
         tick();
      end
      waitrequest = 1'b0;
      readdata = 32'h55AA_55AA;
      tick();
      exp_d_rdata = 32'h55AA_55AA;
      n_vec++; if (d_done !== 1'b1 || d_err !== 1'b0 || d_rdata !== exp_d_rdata) begin $display("FAIL nolimit_done: got done=%b err=%b rdata=%h want 1 0 %h", d_done, d_err, d_rdata, exp_d_rdata); n_miss++; end
      d_req = 1'b0;
      tick();
      pulse_reset();
   endtask

   task automatic test_reset_in_access;
      d_addr = 32'h0000_0080;
      d_size = 2'b10;
      d_we = 1'b0;
      waitrequest = 1'b1;
      d_req = 1'b1;
      tick();
      tick();
      n_vec++; if (read !== 1'b1) begin $display("FAIL rst_access_pre: got r=%b want 1", read); n_miss++; end
      reset = 1'b1;
      d_req = 1'b0;
      tick();
      n_vec++; if (read !== 1'b0 || busy !== 1'b0 || d_done !== 1'b0) begin $display("FAIL rst_access_drop: got r=%b busy=%b done=%b want 0 0 0", read, busy, d_done); n_miss++; end
      reset = 1'b0;
      exp_d_rdata = '0;
      exp_f_rdata = '0;
      waitrequest = 1'b0;
      tick();
      n_vec++; if (d_done !== 1'b0 || read !== 1'b0) begin $display("FAIL rst_access_nodone: got done=%b r=%b want 0 0", d_done, read); n_miss++; end
      f_addr = 32'h0000_0300;
      readdata = 32'h1111_2222;
      f_req = 1'b1;
      tick();
      n_vec++; if (read !== 1'b1 || address !== 32'h300) begin $display("FAIL rst_access_next: got r=%b addr=%h want 1 00000300", read, address); n_miss++; end
      tick();
      exp_f_rdata = 32'h1111_2222;
      n_vec++; if (f_done !== 1'b1 || f_rdata !== exp_f_rdata) begin $display("FAIL rst_access_next_done: got done=%b rdata=%h want 1 %h", f_done, f_rdata, exp_f_rdata); n_miss++; end
      f_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store(32'h0000_1003, 2'b00, 32'h5A5A_5AAB, 3, 4'b1000, 32'hAB00_0000);
      test_store(32'h0000_1001, 2'b00, 32'hFFFF_FF12, 0, 4'b0010, 32'h0000_1200);
      test_store(32'h0000_2002, 2'b01, 32'hDEAD_BEEF, 0, 4'b1100, 32'hBEEF_0000);
      test_store(32'h0000_2000, 2'b01, 32'hDEAD_BEEF, 1, 4'b0011, 32'h0000_BEEF);
      test_store(32'h0000_1004, 2'b10, 32'h1234_5678, 0, 4'b1111, 32'h1234_5678);
      test_load(32'h0000_2002, 2'b01, 1'b1, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
      test_load(32'h0000_2002, 2'b01, 1'b0, 32'h8001_1234, 4'b1100, 32'h0000_8001);
      test_load(32'h0000_3001, 2'b00, 1'b1, 32'h0000_80FF, 4'b0010, 32'hFFFF_FF80);
      test_load(32'h0000_3003, 2'b00, 1'b0, 32'h7F00_0000, 4'b1000, 32'h0000_007F);
      test_load(32'h0000_4000, 2'b10, 1'b1, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
      test_misaligned(1'b0, 32'h0000_0006, 2'b10);
      test_misaligned(1'b0, 32'h0000_2001, 2'b01);
      test_misaligned(1'b0, 32'h0000_0010, 2'b11);
      test_misaligned(1'b1, 32'h0000_0102, 2'b10);
      test_contention();
      test_timeout();
      test_reset_in_access();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
